// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 constants and word helpers shared by key expansion and the round datapath
package aes_pkg;
   localparam int NR = 10;
   localparam int KEY_W = 128;
   // Entry 0 and 11..15 are padding so a 4-bit round counter can index the table directly
   localparam logic [0:15][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational FIPS-197 forward S-box, one byte in, one byte out
module aes_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);
   localparam logic [0:255][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };
   assign out_o = SBOX[in_i];
endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128 key expansion, one round key per cycle into an 11-entry store
// read back by index with one cycle of latency.
module aes_key_schedule
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             key_load,
   input  logic [KEY_W-1:0] init_key,
   input  logic [3:0]       rk_idx,
   output logic [KEY_W-1:0] round_key,
   output logic             busy,
   output logic             key_ready
);
   localparam logic [3:0] LAST = 4'(NR);
   logic [KEY_W-1:0] rk_q [0:NR];
   logic [KEY_W-1:0] wk_q, wk_d, round_key_q;
   logic [3:0]       cnt_q;
   logic             busy_q, ready_q;
   logic [31:0]      rw, sw, t, w0, w1, w2, w3;
   assign rw = rot_word(wk_q[31:0]);
   for (genvar b = 0; b < 4; b++) begin : g_sub
      aes_sbox u_sbox (.in_i(rw[8*b +: 8]), .out_o(sw[8*b +: 8]));
   end
   assign t    = sw ^ {RCON[cnt_q], 24'h0};
   assign w0   = wk_q[127:96] ^ t;
   assign w1   = w0 ^ wk_q[95:64];
   assign w2   = w1 ^ wk_q[63:32];
   assign w3   = w2 ^ wk_q[31:0];
   assign wk_d = {w0, w1, w2, w3};
   // A load takes priority over an in-flight expansion, discarding the partial schedule
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
         wk_q        <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b0;
         round_key_q <= '0;
      end else begin
         round_key_q <= (rk_idx <= LAST) ? rk_q[rk_idx] : '0;
         if (key_load) begin
            rk_q[0] <= init_key;
            wk_q    <= init_key;
            cnt_q   <= 4'd1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
         end else if (busy_q) begin
            rk_q[cnt_q] <= wk_d;
            wk_q        <= wk_d;
            cnt_q       <= (cnt_q == LAST) ? 4'd0 : cnt_q + 4'd1;
            busy_q      <= cnt_q != LAST;
            ready_q     <= cnt_q == LAST;
         end
      end
   end
   assign round_key = round_key_q;
   assign busy      = busy_q;
   assign key_ready = ready_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: scoreboard bench for the AES-128 key schedule against FIPS-197 vectors
// and an independent GF(2^8) reference model.
module tb_aes_key_schedule;
   logic         clk = 1'b0, reset = 1'b0, key_load = 1'b0;
   logic [127:0] init_key = '0;
   logic [3:0]   rk_idx = '0;
   logic [127:0] round_key;
   logic         busy, key_ready;
   int           vec = 0, errs = 0;
   logic [127:0] sbq [$];
   logic [127:0] exp_v;

   localparam logic [127:0] KA  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K1S = 128'h11111111222222223333333344444444;

   aes_key_schedule dut (
      .clk(clk), .reset(reset), .key_load(key_load), .init_key(init_key),
      .rk_idx(rk_idx), .round_key(round_key), .busy(busy), .key_ready(key_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] msbox(input logic [7:0] x);
      logic [7:0] y = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(x, 8'(c)) == 8'h01) y = 8'(c);
      return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] mrk(input logic [127:0] k, input int r);
      logic [7:0]  rc = 8'h01;
      logic [31:0] t;
      for (int i = 1; i <= r; i++) begin
         t = {msbox(k[23:16]), msbox(k[15:8]), msbox(k[7:0]), msbox(k[31:24])};
         t[31:24] ^= rc;
         k[127:96] ^= t;
         k[95:64]  ^= k[127:96];
         k[63:32]  ^= k[95:64];
         k[31:0]   ^= k[63:32];
         rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      return k;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [127:0] k);
      init_key = k;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
   endtask

   task automatic req(input logic [3:0] i, input logic [127:0] e);
      rk_idx = i;
      sbq.push_back(e);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      #3;
      vec++;
      if ({busy, key_ready} !== 2'b00 || round_key !== '0) begin
         errs++;
         $display("FAIL reset_state busy=%b ready=%b rk=%h want 0 0 0", busy, key_ready, round_key);
      end
      @(negedge clk);
      reset = 1'b1;
      req(4'd5, '0);
      tick();
      exp_v = sbq.pop_front();
      vec++;
      if (round_key !== exp_v) begin
         errs++;
         $display("FAIL reset_store got %h want %h", round_key, exp_v);
      end
   endtask

   task automatic test_fips;
      logic [127:0] tab [3] = '{KA, 128'ha0fafe1788542cb123a339392a6c7605, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      logic [3:0]   ix  [3] = '{4'd0, 4'd1, 4'd10};
      load(KA);
      for (int n = 0; n < 20 && !key_ready; n++) tick();
      vec++;
      if (!key_ready) begin
         errs++;
         $display("FAIL fips_ready got 0 want 1");
      end
      for (int i = 0; i < 3; i++) begin
         req(ix[i], tab[i]);
         tick();
         exp_v = sbq.pop_front();
         vec++;
         if (round_key !== exp_v) begin
            errs++;
            $display("FAIL fips_rk%0d got %h want %h", ix[i], round_key, exp_v);
         end
      end
      for (int i = 0; i <= 10; i++) begin
         req(4'(i), mrk(KA, i));
         tick();
         exp_v = sbq.pop_front();
         vec++;
         if (round_key !== exp_v) begin
            errs++;
            $display("FAIL model_rk%0d got %h want %h", i, round_key, exp_v);
         end
      end
   endtask

   task automatic test_latency;
      load('0);
      for (int e = 0; e < 10; e++) begin
         vec++;
         if ({busy, key_ready} !== 2'b10) begin
            errs++;
            $display("FAIL latency_edge%0d busy=%b ready=%b want 1 0", e, busy, key_ready);
         end
         tick();
      end
      vec++;
      if ({busy, key_ready} !== 2'b01) begin
         errs++;
         $display("FAIL latency_done busy=%b ready=%b want 0 1", busy, key_ready);
      end
   endtask

   task automatic test_zero;
      logic [127:0] tab [3] = '{128'h0, 128'h62636363626363636263636362636363, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
      logic [3:0]   ix  [3] = '{4'd0, 4'd1, 4'd10};
      for (int i = 0; i < 3; i++) begin
         req(ix[i], tab[i]);
         tick();
         exp_v = sbq.pop_front();
         vec++;
         if (round_key !== exp_v) begin
            errs++;
            $display("FAIL zero_rk%0d got %h want %h", ix[i], round_key, exp_v);
         end
      end
   endtask

   task automatic test_restart;
      load(KA);
      repeat (3) tick();
      load(KC);
      for (int e = 0; e < 10; e++) begin
         vec++;
         if ({busy, key_ready} !== 2'b10) begin
            errs++;
            $display("FAIL restart_edge%0d busy=%b ready=%b want 1 0", e, busy, key_ready);
         end
         tick();
      end
      vec++;
      if (key_ready !== 1'b1) begin
         errs++;
         $display("FAIL restart_ready got %b want 1", key_ready);
      end
      req(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      tick();
      exp_v = sbq.pop_front();
      vec++;
      if (round_key !== exp_v) begin
         errs++;
         $display("FAIL restart_rk10 got %h want %h", round_key, exp_v);
      end
   endtask

   task automatic test_load_at_ready;
      load(KA);
      repeat (9) tick();
      load(KC);
      vec++;
      if ({busy, key_ready} !== 2'b10) begin
         errs++;
         $display("FAIL load_wins busy=%b ready=%b want 1 0", busy, key_ready);
      end
      for (int n = 0; n < 20 && !key_ready; n++) tick();
      req(4'd10, mrk(KC, 10));
      tick();
      exp_v = sbq.pop_front();
      vec++;
      if (round_key !== exp_v) begin
         errs++;
         $display("FAIL load_wins_rk10 got %h want %h", round_key, exp_v);
      end
   endtask

   task automatic test_reset_mid;
      rk_idx = 4'd0;
      load(KA);
      repeat (4) tick();
      #2;
      reset = 1'b0;
      #1;
      vec++;
      if ({busy, key_ready} !== 2'b00 || round_key !== '0) begin
         errs++;
         $display("FAIL reset_mid busy=%b ready=%b rk=%h want 0 0 0", busy, key_ready, round_key);
      end
      @(negedge clk);
      reset = 1'b1;
      req(4'd1, '0);
      tick();
      exp_v = sbq.pop_front();
      vec++;
      if (round_key !== exp_v) begin
         errs++;
         $display("FAIL reset_mid_rk1 got %h want %h", round_key, exp_v);
      end
      load(K1S);
      for (int n = 0; n < 20 && !key_ready; n++) tick();
      vec++;
      if (!key_ready) begin
         errs++;
         $display("FAIL reload_ready got 0 want 1");
      end
      for (int i = 0; i <= 10; i += 5) begin
         req(4'(i), mrk(K1S, i));
         tick();
         exp_v = sbq.pop_front();
         vec++;
         if (round_key !== exp_v) begin
            errs++;
            $display("FAIL reload_rk%0d got %h want %h", i, round_key, exp_v);
         end
      end
   endtask

   task automatic test_idx;
      req(4'd12, '0);
      tick();
      exp_v = sbq.pop_front();
      vec++;
      if (round_key !== exp_v) begin
         errs++;
         $display("FAIL idx12 got %h want %h", round_key, exp_v);
      end
      req(4'd1, mrk(K1S, 1));
      #3;
      vec++;
      if (round_key !== '0) begin
         errs++;
         $display("FAIL idx_early got %h want %h", round_key, 128'h0);
      end
      tick();
      exp_v = sbq.pop_front();
      vec++;
      if (round_key !== exp_v) begin
         errs++;
         $display("FAIL idx_next got %h want %h", round_key, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_fips();
      test_latency();
      test_zero();
      test_restart();
      test_load_at_ready();
      test_reset_mid();
      test_idx();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
